pi_pwm_drv: RTL and testbench

PI_PWM_DRV -- requirements
Module: pi_pwm_drv

---
 rtl/pi_pkg.sv | 17 +
 rtl/pi_pwm_dt.sv | 102 ++++++++++
 rtl/pi_pwm_drv.sv | 122 ++++++++++++
 tb/tb_pi_pwm_drv.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// Shared constants and output-FSM state encoding for the PI PWM driver.
// Dead-time insertion is enabled with the PI_PWM_DEADTIME_EN macro.
package pi_pkg;

  localparam int unsigned PWM_W_DEF  = 10;
  localparam int unsigned DEAD_T_DEF = 4;
  localparam int unsigned DT_CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_HI    = 3'd1,
    ST_DT_HL = 3'd2,
    ST_LO    = 3'd3,
    ST_DT_LH = 3'd4
  } pwm_state_e;

endpackage

// File: rtl/pi_pwm_dt.sv
// Output stage: turns the raw PWM level into high/low-side drives.
// With PI_PWM_DEADTIME_EN defined, both sides are held low for DEAD_T cycles
// around every switch; otherwise the low side is the complement of the high side.
module pi_pwm_dt
  import pi_pkg::*;
`ifdef PI_PWM_DEADTIME_EN
#(
  parameter int unsigned DEAD_T = DEAD_T_DEF
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic arm_i,
  output logic pwm_o,
  output logic pwm_n_o
);

  pwm_state_e state_q;
  logic       pwm_q;
  logic       pwm_n_q;
`ifdef PI_PWM_DEADTIME_EN
  logic [DT_CNT_W-1:0] dt_q;
`endif

  // Output FSM; the drive registers are updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
`ifdef PI_PWM_DEADTIME_EN
      dt_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_OFF: begin
          if (arm_i) begin
            state_q <= raw_i ? ST_HI : ST_LO;
            pwm_q   <= raw_i;
            pwm_n_q <= ~raw_i;
          end
        end
`ifdef PI_PWM_DEADTIME_EN
        ST_HI: begin
          if (!raw_i) begin
            state_q <= ST_DT_HL;
            pwm_q   <= 1'b0;
            dt_q    <= DT_CNT_W'(DEAD_T - 1);
          end
        end
        ST_DT_HL: begin
          // A returning raw level cancels the switch without new dead time.
          if (raw_i) begin
            state_q <= ST_HI;
            pwm_q   <= 1'b1;
          end else if (dt_q == '0) begin
            state_q <= ST_LO;
            pwm_n_q <= 1'b1;
          end else begin
            dt_q <= dt_q - DT_CNT_W'(1);
          end
        end
        ST_LO: begin
          if (raw_i) begin
            state_q <= ST_DT_LH;
            pwm_n_q <= 1'b0;
            dt_q    <= DT_CNT_W'(DEAD_T - 1);
          end
        end
        ST_DT_LH: begin
          if (!raw_i) begin
            state_q <= ST_LO;
            pwm_n_q <= 1'b1;
          end else if (dt_q == '0) begin
            state_q <= ST_HI;
            pwm_q   <= 1'b1;
          end else begin
            dt_q <= dt_q - DT_CNT_W'(1);
          end
        end
`else
        ST_HI, ST_LO: begin
          state_q <= raw_i ? ST_HI : ST_LO;
          pwm_q   <= raw_i;
          pwm_n_q <= ~raw_i;
        end
`endif
        default: begin
          state_q <= ST_OFF;
          pwm_q   <= 1'b0;
          pwm_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_o   = pwm_q;
  assign pwm_n_o = pwm_n_q;

endmodule

// File: rtl/pi_pwm_drv.sv
// PI controller word to complementary PWM: clamp, offset-binary duty,
// one-entry shadow loaded at the period wrap, free-running period counter.
// Dead time is inserted only when PI_PWM_DEADTIME_EN is defined.
module pi_pwm_drv
  import pi_pkg::*;
#(
  parameter int unsigned PWM_W  = PWM_W_DEF,
  parameter int unsigned DEAD_T = DEAD_T_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ctrl_i,
  input  logic        ctrl_vld_i,
  output logic        ctrl_rdy_o,
  output logic        pwm_o,
  output logic        pwm_n_o,
  output logic        prd_start_o,
  output logic        sat_o
);

  localparam int               LIM_HI   = (1 << (PWM_W - 1)) - 1;
  localparam int               LIM_LO   = -(1 << (PWM_W - 1));
  localparam logic [PWM_W-1:0] CNT_MAX  = '1;
  localparam logic [PWM_W-1:0] DUTY_MID = {1'b1, {(PWM_W - 1){1'b0}}};

  // Reject an out-of-range dead time at elaboration.
  if (DEAD_T < 1 || DEAD_T > 15) begin : g_bad_dead_t
    $error("pi_pwm_drv: DEAD_T must be in 1..15");
  end

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] duty_act_q, duty_act_d;
  logic [PWM_W-1:0] shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             sat_q, sat_d;
  logic             rdy_q, rdy_d;
  logic             prd_q, prd_d;
  logic             loaded_q, loaded_d;

  logic signed [31:0] ctrl_s;
  logic [PWM_W-1:0]   duty_c;
  logic               sat_c;
  logic               accept_c;
  logic               load_c;
  logic               raw_c;
  logic               arm_c;

  assign ctrl_s = $signed(ctrl_i);

  // Clamp the controller word and convert it to offset-binary duty.
  always_comb begin
    sat_c  = 1'b0;
    duty_c = {~ctrl_i[PWM_W-1], ctrl_i[PWM_W-2:0]};
    if (ctrl_s > LIM_HI) begin
      sat_c  = 1'b1;
      duty_c = '1;
    end else if (ctrl_s < LIM_LO) begin
      sat_c  = 1'b1;
      duty_c = '0;
    end
  end

  // Next-state: accept into the shadow, transfer shadow to active at the wrap.
  always_comb begin
    accept_c      = ctrl_vld_i & rdy_q;
    load_c        = shadow_full_q & (cnt_q == CNT_MAX);
    cnt_d         = cnt_q + PWM_W'(1);
    duty_act_d    = load_c ? shadow_q : duty_act_q;
    loaded_d      = loaded_q | load_c;
    shadow_d      = accept_c ? duty_c : shadow_q;
    shadow_full_d = accept_c | (shadow_full_q & ~load_c);
    sat_d         = accept_c ? sat_c : sat_q;
    rdy_d         = ~shadow_full_d;
    prd_d         = (cnt_q == CNT_MAX);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      duty_act_q    <= DUTY_MID;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      sat_q         <= 1'b0;
      rdy_q         <= 1'b0;
      prd_q         <= 1'b0;
      loaded_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      duty_act_q    <= duty_act_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      sat_q         <= sat_d;
      rdy_q         <= rdy_d;
      prd_q         <= prd_d;
      loaded_q      <= loaded_d;
    end
  end

  assign raw_c = (cnt_q < duty_act_q);
  assign arm_c = loaded_q & (cnt_q == '0);

  pi_pwm_dt
`ifdef PI_PWM_DEADTIME_EN
  #(
    .DEAD_T (DEAD_T)
  )
`endif
  u_dt (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (raw_c),
    .arm_i   (arm_c),
    .pwm_o   (pwm_o),
    .pwm_n_o (pwm_n_o)
  );

  assign ctrl_rdy_o  = rdy_q;
  assign prd_start_o = prd_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_pi_pwm_drv.sv
// Self-checking bench for pi_pwm_drv with a cycle-level behavioural model.
// Works with or without PI_PWM_DEADTIME_EN defined.
module tb_pi_pwm_drv;

  localparam int PERIOD = 1024;
  localparam int MAXC   = PERIOD - 1;
  localparam int DEAD_T = 4;
`ifdef PI_PWM_DEADTIME_EN
  localparam int DTE = DEAD_T;
`else
  localparam int DTE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ctrl = '0;
  logic        vld = 1'b0;
  logic        ctrl_rdy_o, pwm_o, pwm_n_o, prd_start_o, sat_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pi_pwm_drv #(.PWM_W(10), .DEAD_T(DEAD_T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl_i      (ctrl),
    .ctrl_vld_i  (vld),
    .ctrl_rdy_o  (ctrl_rdy_o),
    .pwm_o       (pwm_o),
    .pwm_n_o     (pwm_n_o),
    .prd_start_o (prd_start_o),
    .sat_o       (sat_o)
  );

  // Behavioural model: values expected during the current cycle.
  typedef struct {
    int cnt, duty, sh, run, last, acc_cnt;
    bit full, sat, rdy, prd, loaded, on, pwm, pwn, prev_raw, acc;
  } model_t;

  model_t m = '{cnt: 0, duty: 512, sh: 0, run: 0, last: 0, acc_cnt: -1,
                full: 0, sat: 0, rdy: 0, prd: 0, loaded: 0, on: 0,
                pwm: 0, pwn: 0, prev_raw: 0, acc: 0};

  always @(posedge clk or negedge rst_n) begin : model
    model_t n;
    bit     raw;
    int     v;
    if (!rst_n) begin
      n = '{cnt: 0, duty: 512, sh: 0, run: 0, last: 0, acc_cnt: -1,
            full: 0, sat: 0, rdy: 0, prd: 0, loaded: 0, on: 0,
            pwm: 0, pwn: 0, prev_raw: 0, acc: 0};
    end else begin
      n   = m;
      raw = (m.cnt < m.duty);
      n.run = (raw == m.prev_raw) ? m.run + 1 : 1;
      n.prev_raw = raw;
      if (!m.on) begin
        if (m.loaded && m.cnt == 0) begin
          n.on = 1; n.pwm = raw; n.pwn = !raw; n.last = raw ? 1 : 2;
        end
      end else begin
`ifdef PI_PWM_DEADTIME_EN
        // A side turns on immediately if it was the last side driven,
        // otherwise only once raw has held the level for more than DEAD_T cycles.
        n.pwm = raw && (m.last == 1 || n.run > DEAD_T);
        n.pwn = !raw && (m.last == 2 || n.run > DEAD_T);
        if (n.pwm) n.last = 1;
        if (n.pwn) n.last = 2;
`else
        n.pwm = raw; n.pwn = !raw;
`endif
      end
      n.prd = (m.cnt == MAXC);
      n.acc = vld && m.rdy;
      if (m.full && m.cnt == MAXC) begin
        n.duty = m.sh; n.loaded = 1; n.full = 0;
      end
      if (n.acc) begin
        v = $signed(ctrl);
        if (v > 511)       begin n.sh = 1023;    n.sat = 1; end
        else if (v < -512) begin n.sh = 0;       n.sat = 1; end
        else               begin n.sh = v + 512; n.sat = 0; end
        n.full = 1;
        n.acc_cnt = m.cnt;
      end
      n.rdy = !n.full;
      n.cnt = (m.cnt + 1) % PERIOD;
    end
    m <= n;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (m.cnt != target && n < 2100) begin tick(); n++; end
    chk("wait_cnt", m.cnt, target);
  endtask

  task automatic send(input int v, output int cnt_at);
    int n = 0;
    ctrl = 32'(v);
    vld  = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!m.acc && n < 3000);
    #1;
    vld  = 1'b0;
    ctrl = $urandom;
    chk("accept_timeout", int'(m.acc), 1);
    cnt_at = m.acc_cnt;
  endtask

  task automatic measure(output int highs, output int len);
    int n = 0;
    highs = 0;
    len   = 0;
    do begin @(negedge clk); n++; end while (!prd_start_o && n < 2100);
    do begin
      highs += int'(pwm_o);
      len++;
      @(negedge clk);
    end while (!prd_start_o && len < 2100);
  endtask

  initial begin
    int h, l, c, idle, v, r;

    fork
      forever begin
        @(negedge clk);
        chk("pwm_o", int'(pwm_o), int'(m.pwm));
        chk("pwm_n_o", int'(pwm_n_o), int'(m.pwn));
        chk("prd_start_o", int'(prd_start_o), int'(m.prd));
        chk("ctrl_rdy_o", int'(ctrl_rdy_o), int'(m.rdy));
        chk("sat_o", int'(sat_o), int'(m.sat));
        chk("overlap", int'(pwm_o & pwm_n_o), 0);
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", int'(ctrl_rdy_o), 0);
    chk("rst_pwm", int'(pwm_o), 0);
    chk("rst_pwm_n", int'(pwm_n_o), 0);
    chk("rst_prd", int'(prd_start_o), 0);
    chk("rst_sat", int'(sat_o), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick();
    chk("rdy_after_release", int'(ctrl_rdy_o), 1);

    // Zero command: first period enters HI directly, next is steady
    send(0, c);
    measure(h, l);
    chk("zero_first_highs", h, 512);
    measure(h, l);
    chk("zero_highs", h, 512 - DTE);
    chk("zero_period", l, 1024);
    chk("zero_sat", int'(sat_o), 0);

    send(350, c);
    measure(h, l); measure(h, l);
    chk("d862_highs", h, 862 - DTE);
    chk("d862_sat", int'(sat_o), 0);

    send(100000, c);
    measure(h, l); measure(h, l);
    chk("d1023_highs", h, 1023);
    chk("d1023_sat", int'(sat_o), 1);

    send(-100000, c);
    measure(h, l); measure(h, l);
    chk("d0_highs", h, 0);
    chk("d0_sat", int'(sat_o), 1);

    send(-510, c);
    measure(h, l); measure(h, l);
    chk("d2_highs", h, (DTE >= 2) ? 0 : 2);

    // Back-to-back samples: second stalls until the wrap
    send(100, c);
    chk("b2b_rdy_low", int'(ctrl_rdy_o), 0);
    send(188, c);
    chk("b2b_second_cnt", c, 0);
    measure(h, l);
    chk("b2b_d700_highs", h, 700 - DTE);

    // Sample accepted at cnt = 1023 applies one period later
    wait_cnt(MAXC);
    send(-300, c);
    chk("late_acc_cnt", c, MAXC);
    measure(h, l);
    chk("late_old_highs", h, 700 - DTE);
    measure(h, l);
    chk("late_new_highs", h, 212 - DTE);

    // Mid-period reset with a pending sample
    wait_cnt(100);
    send(-200, c);
    wait_cnt(300);
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm_o), 0);
    chk("arst_pwm_n", int'(pwm_n_o), 0);
    chk("arst_rdy", int'(ctrl_rdy_o), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    idle = 0;
    repeat (2100) begin
      @(negedge clk);
      idle += int'(pwm_o | pwm_n_o);
    end
    chk("post_rst_off", idle, 0);
    send(0, c);
    measure(h, l); measure(h, l);
    chk("post_rst_highs", h, 512 - DTE);

    // Randomized samples
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 1200)) tick();
      r = $urandom_range(0, 9);
      case (r)
        6:       v = ($urandom_range(0, 1) == 0) ? 511 : 512;
        7:       v = ($urandom_range(0, 1) == 0) ? -512 : -513;
        8:       v = $urandom_range(600, 100000);
        9:       v = -$urandom_range(600, 100000);
        default: v = $urandom_range(0, 1023) - 512;
      endcase
      send(v, c);
    end
    repeat (2100) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
